aes_key_reverse_128: RTL and testbench
======================================

# aes_key_reverse_128

Iterative AES-128 reverse key scheduler for the decryption datapath. It takes the final round key (round 10) and emits round keys 10, 9, …, 0 in that order, one per accepted beat, over a valid/ready stream. The inverse cipher consumes round keys in this order, so the 11×128-bit key store needed for forward expansion is not required. Round logic uses one SubWord (four `sbox` instances) and one 128-bit state register.

## Interface
- No parameters; key size fixed at 128 bits, 10 rounds.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new sequence; sampled only while `busy`=0.
- `key_last`  in  128  round-10 key {w40,w41,w42,w43}; captured on accepted `start`.
- `key_ready`  in  1  consumer accepts the current beat when high with `key_valid`.
- `key_valid`  out  1  `round_key`/`round_idx` are valid.
- `round_key`  out  128  current round key {w4i,w4i+1,w4i+2,w4i+3}.
- `round_idx`  out  4  round number i of `round_key`, 10 down to 0.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse after round 0 is accepted.

## Operation
- States: IDLE, STREAM. Reset state is IDLE.
- IDLE: `start`=1 captures `key_last` into state register, sets `round_idx`=10, goes to STREAM.
- STREAM: `key_valid`=1. `round_key` = state register.
- Handshake (`key_valid`&`key_ready`) with `round_idx`>0: state ← previous round key, `round_idx` decrements. With `key_ready`=0, state and index hold.
- Handshake with `round_idx`=0: go to IDLE and pulse `done`.
- Previous-key derivation from current {a,b,c,d} = {w4i..w4i+3}:
  - d' = d^c, c' = c^b, b' = b^a.
  - a' = a ^ SubWord(RotWord(d')) ^ {rcon(i),24'h0}.
  - RotWord(x) = {x[23:0],x[31:24]}. SubWord applies `sbox` bytewise.
  - rcon(i) for i=10..1 = 36,1b,80,40,20,10,08,04,02,01 (hex).
  - d' is a combinational term from the current register. SubWord sits on the combinational path into the register.
- `start` while `busy`=1 is ignored, and `key_last` is not re-sampled.
- `key_last` may change freely after capture.
- Output values while `key_valid`=0: `round_key` holds the last register value, `round_idx` holds its value. Consumers must not use them.

## Timing
- Reset (async assert, sync release): `key_valid`=0, `busy`=0, `done`=0, `round_idx`=0, `round_key`=128'h0, state IDLE.
- `start` accepted at edge t: at t+1, `key_valid`=1, `busy`=1, `round_idx`=10, `round_key`=`key_last`.
- With `key_ready` held high, round i appears at cycle t+11−i. Round 0 is at t+11.
- Total sequence is 11 beats. Each `key_ready`-low cycle adds exactly one cycle of stall.
- `done`=1 for exactly one cycle, in the cycle after the round-0 handshake. In that cycle `busy`=0 and `key_valid`=0.
- `start` is accepted in the same cycle `done` is high, so sequences can run back-to-back with a one-cycle gap.
- `rst_n` asserted mid-sequence clears everything immediately. No `done` is produced, and the next sequence requires a fresh `start`.
- Throughput: one round key per cycle. Datapath is single-cycle (3 XOR levels + sbox).

## Test plan
- FIPS-197 A.1: `key_last`=d014f9a8c9ee2589e13f0cc8b6630ca6, `key_ready`=1.
  - Round 10 = `key_last` at t+1.
  - Round 9 = ac7766f319fadc2128d12941575c006e.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 0 = 2b7e151628aed2a6abf7158809cf4f3c at t+11.
  - `done` at t+12.
- Backpressure: same vector with `key_ready` toggled pseudo-randomly.
  - Identical 11-key sequence.
  - `round_key`/`round_idx` stable during every stall cycle.
  - `done` delayed by the number of stall cycles.
- Start while busy: pulse `start` with a different `key_last` at beats 3 and 10.
  - Sequence is unchanged.
  - Exactly one `done`.
- Back-to-back: second `start` in the `done` cycle with `key_last`=all-zero key's round 10 (b4ef5bcb3e92e21123e951cf6f8f188e).
  - Second sequence ends at round 0 = 128'h0.
- Reset mid-sequence: drop `rst_n` at beat 5.
  - Outputs go to reset values without waiting for `clk`.
  - No `done`.
  - A new `start` yields the full 11-beat sequence from round 10.
- Cross-check: random `key_last` values against a reference model running forward expansion.
  - Forward expansion of emitted round 0 must reproduce `key_last` and every emitted round key.

Source files
------------

// File: rtl/aes_key_reverse_128.sv
// rtl/aes_key_reverse_128.sv - iterative AES-128 reverse key scheduler emitting round keys 10..0
module aes_key_reverse_128 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_last,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    // AES forward S-box, byte 0x00 in the most significant position
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [127:0]  key_q, key_d;
    logic [3:0]    idx_q, idx_d;
    logic          done_q, done_d;

    logic [31:0]   w_a, w_b, w_c, w_d;
    logic [31:0]   prev_a, prev_b, prev_c, prev_d;
    logic [31:0]   rot_word, sub_word;
    logic [127:0]  prev_key;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] pos;
        pos = 11'd2047 - {x, 3'b000};
        return SBOX_TABLE[pos -: 8];
    endfunction

    // Round constant used when stepping from round i back to round i-1
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd10:   return 8'h36;
            4'd9:    return 8'h1b;
            4'd8:    return 8'h80;
            4'd7:    return 8'h40;
            4'd6:    return 8'h20;
            4'd5:    return 8'h10;
            4'd4:    return 8'h08;
            4'd3:    return 8'h04;
            4'd2:    return 8'h02;
            4'd1:    return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    assign w_a = key_q[127:96];
    assign w_b = key_q[95:64];
    assign w_c = key_q[63:32];
    assign w_d = key_q[31:0];

    // Undo the forward recurrence: the last word of the previous key is d^c,
    // and it feeds the single SubWord that recovers the first word.
    assign prev_d   = w_d ^ w_c;
    assign prev_c   = w_c ^ w_b;
    assign prev_b   = w_b ^ w_a;
    assign rot_word = {prev_d[23:0], prev_d[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign sub_word[8*g +: 8] = sbox(rot_word[8*g +: 8]);
    end

    assign prev_a   = w_a ^ sub_word ^ {rcon(idx_q), 24'h0};
    assign prev_key = {prev_a, prev_b, prev_c, prev_d};

    // State, key and index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= 128'h0;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Next-state: load on start, step back one round per accepted beat
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_last;
                    idx_d   = 4'd10;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (key_ready) begin
                    if (idx_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = prev_key;
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign done      = done_q;
    assign round_key = key_q;
    assign round_idx = idx_q;

endmodule

// File: tb/tb_aes_key_reverse_128.sv
// tb/tb_aes_key_reverse_128.sv - randomized self-checking bench for aes_key_reverse_128
module tb_aes_key_reverse_128;

    localparam logic [127:0] FIPS_K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_K9   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] ZERO_K10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_last;
    logic         key_ready;
    logic         key_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]   sbox_ref [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] obs [0:10];

    always #5 clk = ~clk;

    aes_key_reverse_128 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_last  (key_last),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, a, b;
        p = 8'h00;
        a = x;
        b = y;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from GF(2^8) inverse plus affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward key expansion of round-0 key into exp_rk[0..10]
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("done_single_cycle", done, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    // One full sequence; called at posedge+1 with the DUT idle
    task automatic run_seq(input logic [127:0] k0, input int ready_pct,
                           input bit busy_starts, input int reset_beat);
        int  e, cyc, stalls, beat;
        bit  rdy;
        expand(k0);
        start    = 1'b1;
        key_last = exp_rk[10];
        @(posedge clk); #1;
        start    = 1'b0;
        key_last = {$urandom(), $urandom(), $urandom(), $urandom()};
        e = 10;
        cyc = 1;
        stalls = 0;
        check("done_low_after_start", done, 1'b0);
        check("busy_after_start", busy, 1'b1);
        while (1) begin
            if (cyc > 300) begin
                check("timeout_done_seen", done, 1'b1);
                start = 1'b0;
                key_ready = 1'b0;
                return;
            end
            beat = 10 - e;
            check("key_valid", key_valid, 1'b1);
            check($sformatf("round_idx[%0d]", e), round_idx, 128'(e));
            check($sformatf("round_key[%0d]", e), round_key, exp_rk[e]);
            check("done_mid_sequence", done, 1'b0);
            obs[e] = round_key;
            if (reset_beat == beat) begin
                start = 1'b0;
                key_ready = 1'b0;
                rst_n = 1'b0;
                #1;
                check("rst_key_valid", key_valid, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_done", done, 1'b0);
                check("rst_round_idx", round_idx, 4'd0);
                check("rst_round_key", round_key, 128'h0);
                @(posedge clk); #2;
                rst_n = 1'b1;
                repeat (3) begin
                    @(posedge clk); #1;
                    check("no_done_after_reset", done, 1'b0);
                    check("idle_after_reset", busy, 1'b0);
                end
                return;
            end
            start = busy_starts && (beat == 3 || beat == 10);
            if (start) key_last = ~exp_rk[10];
            rdy = ($urandom_range(99) < ready_pct);
            key_ready = rdy;
            @(posedge clk); #1;
            cyc++;
            if (rdy) begin
                if (e == 0) break;
                e--;
            end else begin
                stalls++;
            end
        end
        start = 1'b0;
        key_ready = 1'b0;
        check("done_pulse", done, 1'b1);
        check("busy_in_done", busy, 1'b0);
        check("valid_in_done", key_valid, 1'b0);
        check("done_cycle", 128'(cyc), 128'(12 + stalls));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        key_ready = 1'b0;
        key_last = 128'h0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        check("reset_key_valid", key_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_round_idx", round_idx, 4'd0);
        check("reset_round_key", round_key, 128'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_seq(FIPS_K0, 100, 1'b0, -1);
        check("fips_round10", obs[10], FIPS_K10);
        check("fips_round9", obs[9], FIPS_K9);
        check("fips_round1", obs[1], FIPS_K1);
        check("fips_round0", obs[0], FIPS_K0);
        idle_cycle();

        run_seq(FIPS_K0, 50, 1'b0, -1);
        idle_cycle();

        run_seq(FIPS_K0, 100, 1'b1, -1);
        idle_cycle();

        run_seq(FIPS_K0, 100, 1'b0, -1);
        run_seq(128'h0, 100, 1'b0, -1);
        check("b2b_round10", obs[10], ZERO_K10);
        check("b2b_round0", obs[0], 128'h0);
        idle_cycle();

        run_seq(FIPS_K0, 100, 1'b0, 5);
        run_seq(FIPS_K0, 100, 1'b0, -1);
        idle_cycle();

        for (int n = 0; n < 8; n++) begin
            run_seq({$urandom(), $urandom(), $urandom(), $urandom()}, 70, 1'b0, -1);
            idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
